// File: rtl/rt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rt_pkg                                                            |
// | Brief  : Shared ray/triangle types, Q16.16 constants and scheduler states. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package rt_pkg;

    typedef logic signed [0:2][31:0] vec3_t;
    typedef vec3_t [0:1]             ray_t;
    typedef vec3_t [0:2]             tri_t;

    localparam logic signed [31:0] Q16_ONE = 32'sh0001_0000;
    localparam logic signed [31:0] T_INF   = 32'sh7FFF_FFFF;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_EVAL  = 3'd3;
    localparam state_t ST_CHECK = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/closest_hit_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : closest_hit_tracker                                               |
// | Brief  : Keeps the nearest valid hit (t, index, normal) seen for one ray.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module closest_hit_tracker
    import rt_pkg::*;
#(
    parameter int IDX_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_check,
    input  logic               i_result,
    input  logic               i_invalid,
    input  logic signed [31:0] i_t,
    input  vec3_t              i_normal,
    input  logic [IDX_W-1:0]   i_idx,
    output logic               o_hit,
    output logic [IDX_W-1:0]   o_best_idx,
    output logic signed [31:0] o_best_t,
    output vec3_t              o_best_normal,
    output logic               o_any_invalid
);

    logic               r_hit;
    logic [IDX_W-1:0]   r_best_idx;
    logic signed [31:0] r_best_t;
    vec3_t              r_best_normal;
    logic               r_any_invalid;
    logic               w_better;

    // Strict less-than: an equal t later in the list never displaces the earlier index.
    assign w_better = i_result && (i_t < r_best_t);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hit         <= 1'b0;
            r_best_idx    <= '0;
            r_best_t      <= T_INF;
            r_best_normal <= '0;
            r_any_invalid <= 1'b0;
        end else if (i_clear) begin
            r_hit         <= 1'b0;
            r_best_idx    <= '0;
            r_best_t      <= T_INF;
            r_best_normal <= '0;
            r_any_invalid <= 1'b0;
        end else if (i_check) begin
            if (i_invalid) begin
                r_any_invalid <= 1'b1;
            end else if (w_better) begin
                r_hit         <= 1'b1;
                r_best_idx    <= i_idx;
                r_best_t      <= i_t;
                r_best_normal <= i_normal;
            end
        end
    end

    assign o_hit         = r_hit;
    assign o_best_idx    = r_best_idx;
    assign o_best_t      = r_best_t;
    assign o_best_normal = r_best_normal;
    assign o_any_invalid = r_any_invalid;

endmodule
`default_nettype wire

// File: rtl/ray_tri_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ray_tri_scheduler                                                 |
// | Brief  : Walks a triangle list for one ray through an external intersect  |
// |          datapath and returns the closest valid hit.                       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module ray_tri_scheduler
    import rt_pkg::*;
#(
    parameter int IDX_W     = 16,
    parameter int MEM_LAT   = 1,
    parameter int ISECT_LAT = 0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ray_valid,
    output logic               o_ray_ready,
    input  ray_t               i_ray,
    input  logic [IDX_W-1:0]   i_num_tris,
    output logic               o_tri_rd,
    output logic [IDX_W-1:0]   o_tri_addr,
    input  tri_t               i_tri_data,
    output ray_t               o_isect_ray,
    output tri_t               o_isect_tri,
    input  logic               i_isect_result,
    input  logic               i_isect_invalid,
    input  logic signed [31:0] i_isect_t,
    input  vec3_t              i_isect_normal,
    output logic               o_hit_valid,
    input  logic               i_hit_ready,
    output logic               o_hit,
    output logic [IDX_W-1:0]   o_hit_idx,
    output logic signed [31:0] o_hit_t,
    output vec3_t              o_hit_normal,
    output logic               o_any_invalid
);

    localparam int c_CNT_W = 8;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_num_tris;
    logic [c_CNT_W-1:0] r_cnt;
    ray_t               r_isect_ray;
    tri_t               r_isect_tri;
    logic               w_accept;
    logic               w_last;

    assign w_accept = (r_state == ST_IDLE) && i_ray_valid;
    assign w_last   = (r_idx == (r_num_tris - IDX_W'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_num_tris  <= '0;
            r_cnt       <= '0;
            r_isect_ray <= '0;
            r_isect_tri <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_ray_valid) begin
                        r_isect_ray <= i_ray;
                        r_num_tris  <= i_num_tris;
                        if (i_num_tris == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= '0;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    r_cnt   <= c_CNT_W'(MEM_LAT - 1);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_isect_tri <= i_tri_data;
                        if (ISECT_LAT > 0) begin
                            r_cnt   <= c_CNT_W'((ISECT_LAT > 0) ? ISECT_LAT - 1 : 0);
                            r_state <= ST_EVAL;
                        end else begin
                            r_state <= ST_CHECK;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    if (i_hit_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    closest_hit_tracker #(
        .IDX_W (IDX_W)
    ) u_tracker (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_clear       (w_accept),
        .i_check       (r_state == ST_CHECK),
        .i_result      (i_isect_result),
        .i_invalid     (i_isect_invalid),
        .i_t           (i_isect_t),
        .i_normal      (i_isect_normal),
        .i_idx         (r_idx),
        .o_hit         (o_hit),
        .o_best_idx    (o_hit_idx),
        .o_best_t      (o_hit_t),
        .o_best_normal (o_hit_normal),
        .o_any_invalid (o_any_invalid)
    );

    // Address only moves on entry to FETCH, so it holds the last index in every other state.
    assign o_ray_ready = (r_state == ST_IDLE);
    assign o_tri_rd    = (r_state == ST_FETCH);
    assign o_tri_addr  = r_idx;
    assign o_hit_valid = (r_state == ST_DONE);
    assign o_isect_ray = r_isect_ray;
    assign o_isect_tri = r_isect_tri;

endmodule
`default_nettype wire

// File: tb/tb_ray_tri_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ray_tri_scheduler                                              |
// | Brief  : Scoreboard bench with stub triangle memory and scripted datapath. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ray_tri_scheduler;
    import rt_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ray_valid;
    logic        ray_ready;
    ray_t        ray_in;
    logic [15:0] num_tris;
    logic        tri_rd;
    logic [15:0] tri_addr;
    tri_t        tri_data;
    ray_t        isect_ray;
    tri_t        isect_tri;
    logic        isect_result;
    logic        isect_invalid;
    logic [31:0] isect_t;
    vec3_t       isect_normal;
    logic        hit_valid;
    logic        hit_ready;
    logic        hit;
    logic [15:0] hit_idx;
    logic [31:0] hit_t;
    vec3_t       hit_normal;
    logic        any_invalid;

    typedef struct {
        logic        hit;
        logic [15:0] idx;
        logic [31:0] t;
        vec3_t       nrm;
        logic        inv;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] rd_q[$];
    int          n_tot = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    bit          res_tab[16];
    bit          inv_tab[16];
    int          t_tab[16];
    logic [3:0]  dp_k;

    ray_tri_scheduler dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_ray_valid     (ray_valid),
        .o_ray_ready     (ray_ready),
        .i_ray           (ray_in),
        .i_num_tris      (num_tris),
        .o_tri_rd        (tri_rd),
        .o_tri_addr      (tri_addr),
        .i_tri_data      (tri_data),
        .o_isect_ray     (isect_ray),
        .o_isect_tri     (isect_tri),
        .i_isect_result  (isect_result),
        .i_isect_invalid (isect_invalid),
        .i_isect_t       (isect_t),
        .i_isect_normal  (isect_normal),
        .o_hit_valid     (hit_valid),
        .i_hit_ready     (hit_ready),
        .o_hit           (hit),
        .o_hit_idx       (hit_idx),
        .o_hit_t         (hit_t),
        .o_hit_normal    (hit_normal),
        .o_any_invalid   (any_invalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec3_t nrm_of(input int k);
        vec3_t v;
        v[0] = 32'(k * 3 + 1);
        v[1] = 32'(k * 5 + 2);
        v[2] = 32'(k * 7 + 3);
        return v;
    endfunction

    function automatic tri_t make_tri(input logic [15:0] a);
        tri_t r;
        r       = '0;
        r[0][0] = {16'h0, a};
        r[1][1] = {16'hA5A5, a};
        r[2][2] = 32'h1234_0000 | {16'h0, a};
        return r;
    endfunction

    // Stub memory: one cycle of read latency; the scripted datapath keys off the captured index.
    always @(posedge clk) if (tri_rd) tri_data <= make_tri(tri_addr);
    always @(negedge clk) if (tri_rd) rd_q.push_back(tri_addr);

    assign dp_k          = isect_tri[0][0][3:0];
    assign isect_result  = res_tab[dp_k];
    assign isect_invalid = inv_tab[dp_k];
    assign isect_t       = t_tab[dp_k];
    assign isect_normal  = nrm_of(int'(dp_k));

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_tri(input int i, input bit r, input bit v, input int t);
        res_tab[i] = r;
        inv_tab[i] = v;
        t_tab[i]   = t;
    endtask

    function automatic exp_t model(input int n);
        exp_t e;
        e.hit = 1'b0; e.idx = '0; e.t = 32'h7FFF_FFFF; e.nrm = '0; e.inv = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (inv_tab[i]) e.inv = 1'b1;
            else if (res_tab[i] && (t_tab[i] < $signed(e.t))) begin
                e.hit = 1'b1; e.idx = 16'(i); e.t = t_tab[i]; e.nrm = nrm_of(i);
            end
        end
        return e;
    endfunction

    task automatic rand_ray();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++)
                ray_in[i][j] = 32'($urandom);
    endtask

    task automatic run_ray(input int n, input int hold);
        exp_t e;
        int   acc;
        bit   seen;
        sb.push_back(model(n));
        rd_q.delete();
        rand_ray();
        chk("ray_ready_idle", 192'(ray_ready), 192'(1));
        ray_valid = 1'b1;
        num_tris  = 16'(n);
        @(negedge clk);
        ray_valid = 1'b0;
        acc = cyc;
        chk("isect_ray", isect_ray, ray_in);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (hit_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk("hit_valid_seen", 192'(seen), 192'(1));
        if (!seen) begin void'(sb.pop_front()); return; end
        // Cycles counted from the accept cycle to the first cycle showing hit_valid.
        chk("latency", 192'(cyc - acc + 1), 192'(1 + 3 * n));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 192'(hit_valid), 192'(1));
            chk("hold_ready", 192'(ray_ready), 192'(0));
            chk("hold_rd", 192'(tri_rd), 192'(0));
            chk("hold_t", 192'(hit_t), 192'(sb[0].t));
            chk("hold_idx", 192'(hit_idx), 192'(sb[0].idx));
        end
        e = sb.pop_front();
        chk("hit", 192'(hit), 192'(e.hit));
        chk("hit_idx", 192'(hit_idx), 192'(e.idx));
        chk("hit_t", 192'(hit_t), 192'(e.t));
        chk("hit_normal", 192'(hit_normal), 192'(e.nrm));
        chk("any_invalid", 192'(any_invalid), 192'(e.inv));
        chk("rd_count", 192'(rd_q.size()), 192'(n));
        for (int i = 0; i < rd_q.size() && i < n; i++)
            chk("rd_addr", 192'(rd_q[i]), 192'(i));
        hit_ready = 1'b1;
        @(negedge clk);
        hit_ready = 1'b0;
        chk("post_valid", 192'(hit_valid), 192'(0));
        chk("post_ready", 192'(ray_ready), 192'(1));
    endtask

    task automatic clear_tabs();
        for (int i = 0; i < 16; i++) set_tri(i, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #100us;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        rst_n = 1'b0; ray_valid = 1'b0; hit_ready = 1'b0; num_tris = '0; ray_in = '0;
        clear_tabs();
        repeat (2) @(negedge clk);
        chk("rst_ready", 192'(ray_ready), 192'(1));
        chk("rst_hit_valid", 192'(hit_valid), 192'(0));
        chk("rst_hit_t", 192'(hit_t), 192'(32'h7FFF_FFFF));
        chk("rst_rd", 192'(tri_rd), 192'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Empty list
        run_ray(0, 0);

        // Closest of three hits
        clear_tabs();
        set_tri(0, 1, 0, 32'h5_0000); set_tri(1, 1, 0, 32'h2_0000); set_tri(2, 1, 0, 32'h3_0000);
        run_ray(3, 0);

        // Tie keeps the first index; a miss with a smaller t is ignored
        clear_tabs();
        set_tri(0, 1, 0, 32'h2_0000); set_tri(1, 0, 0, 32'h1_0000); set_tri(2, 1, 0, 32'h2_0000);
        run_ray(3, 0);

        // Invalid triangle with the smaller t is skipped but flagged
        clear_tabs();
        set_tri(0, 1, 1, 32'h1_0000); set_tri(1, 1, 0, 32'h4_0000);
        run_ray(2, 0);

        // Signed compare: negative t wins
        clear_tabs();
        set_tri(0, 1, 0, 32'h1_0000); set_tri(1, 1, 0, -32'sh8000);
        set_tri(2, 0, 0, -32'sh10_0000); set_tri(3, 1, 0, 0);
        run_ray(4, 0);

        // Downstream back-pressure for 10 cycles
        clear_tabs();
        set_tri(0, 1, 0, 32'h3_0000); set_tri(1, 1, 0, 32'h1_8000);
        run_ray(2, 10);

        // Async reset while waiting on the read of triangle 5
        clear_tabs();
        for (int i = 0; i < 8; i++) set_tri(i, 1, 0, 32'h9_0000 - i * 32'h1000);
        rand_ray();
        ray_valid = 1'b1; num_tris = 16'd8;
        @(negedge clk);
        ray_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tri_rd && tri_addr == 16'd5) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("abort_reach", 192'(found), 192'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", 192'(ray_ready), 192'(1));
        chk("abort_valid", 192'(hit_valid), 192'(0));
        chk("abort_hit", 192'(hit), 192'(0));
        chk("abort_t", 192'(hit_t), 192'(32'h7FFF_FFFF));
        chk("abort_addr", 192'(tri_addr), 192'(0));
        chk("abort_isect_ray", isect_ray, 192'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_result", 192'(hit_valid), 192'(0));
        end
        clear_tabs();
        set_tri(0, 1, 0, 32'h7_0000);
        run_ray(1, 0);

        chk("sb_empty", 192'(sb.size()), 192'(0));
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
